multi_entry_accumulator: RTL

- Parametrised successor to the single-register column accumulator.
- Keeps ARR_SIZE independent per-column partial sums for each of DEPTH entries (output tiles), instead of reducing all columns into one scalar.
- Drains a selected entry to the output buffer one word per beat, using a valid/ready handshake.
- Sits between the systolic array's vertical outputs and the output buffer.

---
 rtl/acc_pkg.sv | 26 ++
 rtl/acc_lane.sv | 71 +++++++
 rtl/bfp32_adder.sv | 82 ++++++++
 rtl/multi_entry_accumulator.sv | 114 +++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared bfp32 field layout, constants, drain FSM encoding and a clog2 helper for the accumulator.
package acc_pkg;

  localparam int BFP_EXP_W = 8;
  localparam int BFP_MAN_W = 23;
  localparam int BFP_W     = 1 + BFP_EXP_W + BFP_MAN_W;

  localparam logic [BFP_W-1:0] BFP32_ZERO = 32'h0000_0000;
  localparam logic [BFP_W-1:0] BFP32_MAX  = 32'h7F7F_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } acc_state_e;

  // Never returns 0 so that derived index widths stay legal for tiny parameters.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/acc_lane.sv
// One column lane: DEPTH-entry partial-sum file, one stage of beat registers, a bfp32 add
// written back at the end of the following cycle, and forwarding of the in-flight sum.
module acc_lane
  import acc_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [ENTRY_W-1:0] wr_entry,
  input  logic               wr_first,
  input  logic [BFP_W-1:0]   wr_data,
  input  logic               clear,
  input  logic [ENTRY_W-1:0] rd_entry,
  output logic [BFP_W-1:0]   rd_data,
  output logic               pending
);

  logic [BFP_W-1:0]   acc_q [DEPTH];
  logic               s1_vld;
  logic [ENTRY_W-1:0] s1_entry;
  logic [BFP_W-1:0]   s1_data, s1_opnd;
  logic [BFP_W-1:0]   add_sum, opnd;

  bfp32_adder u_add (
    .a   (s1_data),
    .b   (s1_opnd),
    .sum (add_sum)
  );

  // A clear in the accept cycle means the entry is zero by the time this beat writes back.
  always_comb begin
    opnd = acc_q[wr_entry];
    if (wr_first || clear)
      opnd = BFP32_ZERO;
    else if (s1_vld && s1_entry == wr_entry)
      opnd = add_sum;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld   <= 1'b0;
      s1_entry <= '0;
      s1_data  <= BFP32_ZERO;
      s1_opnd  <= BFP32_ZERO;
    end else begin
      s1_vld <= wr_en;
      if (wr_en) begin
        s1_entry <= wr_entry;
        s1_data  <= wr_data;
        s1_opnd  <= opnd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) acc_q[i] <= BFP32_ZERO;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) acc_q[i] <= BFP32_ZERO;
    end else if (s1_vld) begin
      acc_q[s1_entry] <= add_sum;
    end
  end

  assign rd_data = acc_q[rd_entry];
  assign pending = s1_vld;

endmodule

// File: rtl/bfp32_adder.sv
// Combinational bfp32 adder: round-to-nearest-even, zero-exponent inputs and underflow flush to zero,
// overflow saturates to +/- max finite. Callers register the result.
module bfp32_adder
  import acc_pkg::*;
(
  input  logic [BFP_W-1:0] a,
  input  logic [BFP_W-1:0] b,
  output logic [BFP_W-1:0] sum
);

  localparam int MW = BFP_MAN_W + 1;
  localparam int XW = MW + 3;

  logic [BFP_W-1:0]            x, y;
  logic [BFP_EXP_W-1:0]        ex, ey;
  logic [BFP_EXP_W:0]          dexp;
  logic [XW-1:0]               xe, ye, ye_sh, mask, nrm;
  logic [XW:0]                 raw;
  logic [4:0]                  lz;
  logic                        found, rup;
  logic [MW:0]                 rnd;
  logic signed [BFP_EXP_W+1:0] e_res;

  always_comb begin
    // x always carries the larger magnitude so the subtract never goes negative.
    if (a[BFP_W-2:0] >= b[BFP_W-2:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    ex   = x[BFP_W-2 -: BFP_EXP_W];
    ey   = y[BFP_W-2 -: BFP_EXP_W];
    xe   = (ex == '0) ? '0 : {1'b1, x[BFP_MAN_W-1:0], 3'b000};
    ye   = (ey == '0) ? '0 : {1'b1, y[BFP_MAN_W-1:0], 3'b000};
    dexp = {1'b0, ex} - {1'b0, ey};
    mask = '0;
    if (int'(dexp) >= XW) begin
      ye_sh = {{(XW-1){1'b0}}, |ye};
    end else begin
      mask  = ~({XW{1'b1}} << dexp);
      ye_sh = (ye >> dexp) | {{(XW-1){1'b0}}, |(ye & mask)};
    end

    if (x[BFP_W-1] == y[BFP_W-1]) raw = {1'b0, xe} + {1'b0, ye_sh};
    else                          raw = {1'b0, xe} - {1'b0, ye_sh};

    e_res = $signed({2'b00, ex});
    lz    = '0;
    found = 1'b0;
    if (raw[XW]) begin
      nrm   = raw[XW:1] | {{(XW-1){1'b0}}, raw[0]};
      e_res = e_res + 10'sd1;
    end else begin
      for (int i = XW - 1; i >= 0; i--) begin
        if (!found && raw[i]) begin
          found = 1'b1;
          lz    = 5'(XW - 1 - i);
        end
      end
      nrm   = raw[XW-1:0] << lz;
      e_res = e_res - $signed({5'b00000, lz});
    end

    rup = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
    rnd = {1'b0, nrm[XW-1:3]} + {{MW{1'b0}}, rup};
    if (rnd[MW]) begin
      rnd   = rnd >> 1;
      e_res = e_res + 10'sd1;
    end

    // A missing hidden bit means the exact result was zero.
    if (!rnd[MW-1] || e_res <= 10'sd0)
      sum = BFP32_ZERO;
    else if (e_res >= 10'sd255)
      sum = {x[BFP_W-1], BFP32_MAX[BFP_W-2:0]};
    else
      sum = {x[BFP_W-1], e_res[BFP_EXP_W-1:0], rnd[BFP_MAN_W-1:0]};
  end

endmodule

// File: rtl/multi_entry_accumulator.sv
// Per-column multi-entry bfp32 accumulator with a valid/ready drain of one entry, one lane per beat.
// Optional macro ACC_RELU_EN: drained negative nonzero words are output as zero.
module multi_entry_accumulator
  import acc_pkg::*;
#(
  parameter int  ARR_SIZE    = 4,
  parameter int  VERTICAL_BW = 32,
  parameter int  DEPTH       = 4,
  parameter int  OB_ADDR_W   = 4,
  localparam int ENTRY_W     = clog2(DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [ENTRY_W-1:0]              in_entry,
  input  logic                            in_first,
  input  logic [ARR_SIZE*VERTICAL_BW-1:0] in_data,
  input  logic                            acc_clear,
  input  logic                            store_req,
  input  logic [ENTRY_W-1:0]              store_entry,
  input  logic [OB_ADDR_W-1:0]            store_base,
  output logic                            store_busy,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [VERTICAL_BW-1:0]          out_data,
  output logic [OB_ADDR_W-1:0]            out_addr
);

  localparam int LANE_W = clog2(ARR_SIZE);

  acc_state_e             state_q, state_d;
  logic [ENTRY_W-1:0]     entry_q;
  logic [OB_ADDR_W-1:0]   base_q;
  logic [LANE_W-1:0]      lane_q;
  logic [VERTICAL_BW-1:0] lane_rd [ARR_SIZE];
  logic [VERTICAL_BW-1:0] drain_word;
  logic [ARR_SIZE-1:0]    lane_pend;
  logic                   accept, clear_eff, last_xfer;

  assign in_ready   = (state_q == IDLE) && !store_req;
  assign accept     = in_valid && in_ready;
  assign store_busy = (state_q != IDLE);
  assign clear_eff  = acc_clear && !store_busy;
  assign last_xfer  = out_ready && (lane_q == LANE_W'(ARR_SIZE - 1));

  for (genvar k = 0; k < ARR_SIZE; k++) begin : g_lane
    acc_lane #(
      .DEPTH   (DEPTH),
      .ENTRY_W (ENTRY_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (accept),
      .wr_entry (in_entry),
      .wr_first (in_first),
      .wr_data  (in_data[k*VERTICAL_BW +: VERTICAL_BW]),
      .clear    (clear_eff),
      .rd_entry (entry_q),
      .rd_data  (lane_rd[k]),
      .pending  (lane_pend[k])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Requests arriving while busy are dropped, not queued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (store_req)   state_d = FLUSH;
      FLUSH:   if (~|lane_pend) state_d = DRAIN;
      DRAIN:   if (last_xfer)   state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry_q <= '0;
      base_q  <= '0;
      lane_q  <= '0;
    end else begin
      if (state_q == IDLE && store_req) begin
        entry_q <= store_entry;
        base_q  <= store_base;
      end
      if (state_q == FLUSH)
        lane_q <= '0;
      else if (state_q == DRAIN && out_ready)
        lane_q <= lane_q + 1'b1;
    end
  end

  always_comb begin
    out_valid  = 1'b0;
    out_data   = '0;
    out_addr   = '0;
    drain_word = lane_rd[lane_q];
    if (state_q == DRAIN) begin
      out_valid = 1'b1;
      out_addr  = base_q + OB_ADDR_W'(lane_q);
`ifdef ACC_RELU_EN
      out_data  = (drain_word[VERTICAL_BW-1] && |drain_word[VERTICAL_BW-2:0]) ? '0 : drain_word;
`else
      out_data  = drain_word;
`endif
    end
  end

endmodule
